sqrt_ctrl: RTL



---
 rtl/sqrt_pkg.sv | 47 ++++
 rtl/sqrt_ctrl_if.sv | 27 ++
 rtl/sqrt_ctrl_decode.sv | 68 ++++++
 rtl/sqrt_ctrl.sv | 39 +++
 4 files changed

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: state enum, AU function selects and control-word struct shared by the sqrt_ctrl slice
package sqrt_pkg;
  typedef enum logic [4:0] {
    IDLE   = 5'd0,
    LOAD   = 5'd1,
    ABSA_I = 5'd2,
    ABSA_W = 5'd3,
    ABSB_I = 5'd4,
    ABSB_W = 5'd5,
    MAX_I  = 5'd6,
    MAX_W  = 5'd7,
    MIN_I  = 5'd8,
    MIN_W  = 5'd9,
    SUB_I  = 5'd10,
    SUB_W  = 5'd11,
    ADD_I  = 5'd12,
    ADD_W  = 5'd13,
    FMAX_I = 5'd14,
    FMAX_W = 5'd15,
    DONE   = 5'd16
  } state_t;
  localparam logic [1:0] AU1_ABS_A = 2'b00;
  localparam logic [1:0] AU1_ABS_B = 2'b01;
  localparam logic [1:0] AU1_MAX   = 2'b10;
  localparam logic [1:0] AU1_MIN   = 2'b11;
  localparam logic [1:0] AU2_SUB   = 2'b00;
  localparam logic [1:0] AU2_ADD   = 2'b01;
  localparam logic [1:0] AU2_MAX   = 2'b10;
  typedef struct packed {
    logic       en_R1;
    logic       en_R2;
    logic       en_R3;
    logic       en_R4;
    logic       en_R5;
    logic       b1;
    logic       b6;
    logic [1:0] b2;
    logic [1:0] b3;
    logic [1:0] b4;
    logic [1:0] b5;
    logic [1:0] b7;
    logic [1:0] sel_AU1;
    logic [1:0] sel_AU2;
    logic       Done;
    logic       busy;
  } ctrl_t;
endpackage

// File: rtl/sqrt_ctrl_if.sv
// sqrt_ctrl_if: start/busy handshake plus datapath controls; master=controller, slave=datapath; SQRT_CTRL_ABORT_EN adds abort
interface sqrt_ctrl_if;
  logic start;
`ifdef SQRT_CTRL_ABORT_EN
  logic abort;
`endif
  logic busy;
  logic en_R1, en_R2, en_R3, en_R4, en_R5;
  logic b1, b6;
  logic [1:0] b2, b3, b4, b5, b7;
  logic [1:0] sel_AU1, sel_AU2;
  logic Done;
  modport master(
`ifdef SQRT_CTRL_ABORT_EN
    input abort,
`endif
    input start,
    output busy, en_R1, en_R2, en_R3, en_R4, en_R5, b1, b6, b2, b3, b4, b5, b7, sel_AU1, sel_AU2, Done
  );
  modport slave(
`ifdef SQRT_CTRL_ABORT_EN
    output abort,
`endif
    output start,
    input busy, en_R1, en_R2, en_R3, en_R4, en_R5, b1, b6, b2, b3, b4, b5, b7, sel_AU1, sel_AU2, Done
  );
endinterface

// File: rtl/sqrt_ctrl_decode.sv
// sqrt_ctrl_decode: combinational state -> control word (in: state; out: cw); op pairs share selects, bit 0 of state marks the write-back half
module sqrt_ctrl_decode
  import sqrt_pkg::*;
(
  input  state_t state,
  output ctrl_t  cw
);
  logic wr;
  assign wr = state[0];
  always_comb begin
    cw = '0;
    cw.busy = (state != IDLE) && (state != DONE);
    case (state)
      LOAD: begin
        cw.b3 = 2'b10;
        cw.b4 = 2'b10;
        cw.en_R1 = 1'b1;
        cw.en_R2 = 1'b1;
      end
      ABSA_I, ABSA_W: begin
        cw.b1 = 1'b1;
        cw.sel_AU1 = AU1_ABS_A;
        cw.b3 = {1'b0, wr};
        cw.en_R1 = wr;
      end
      ABSB_I, ABSB_W: begin
        cw.b2 = 2'b01;
        cw.sel_AU1 = AU1_ABS_B;
        cw.b4 = {1'b0, wr};
        cw.en_R2 = wr;
      end
      MAX_I, MAX_W: begin
        cw.b1 = 1'b1;
        cw.b2 = 2'b01;
        cw.sel_AU1 = AU1_MAX;
        cw.b7 = {wr, 1'b0};
        cw.en_R3 = wr;
        cw.en_R4 = wr;
      end
      MIN_I, MIN_W: begin
        cw.b1 = 1'b1;
        cw.b2 = 2'b01;
        cw.sel_AU1 = AU1_MIN;
        cw.en_R5 = wr;
      end
      SUB_I, SUB_W: begin
        cw.b5 = 2'b10;
        cw.sel_AU2 = AU2_SUB;
        cw.b7 = {1'b0, wr};
        cw.en_R3 = wr;
      end
      ADD_I, ADD_W: begin
        cw.b5 = 2'b01;
        cw.sel_AU2 = AU2_ADD;
        cw.b7 = {1'b0, wr};
        cw.en_R3 = wr;
      end
      FMAX_I, FMAX_W: begin
        cw.b5 = 2'b10;
        cw.sel_AU2 = AU2_MAX;
        cw.b7 = {1'b0, wr};
        cw.en_R3 = wr;
      end
      DONE: cw.Done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/sqrt_ctrl.sv
// sqrt_ctrl: sqrt(a^2+b^2) sequencing FSM (clk, async active-low rst_n, bus: sqrt_ctrl_if.master); SQRT_CTRL_ABORT_EN adds bus.abort
module sqrt_ctrl
  import sqrt_pkg::*;
(
  input logic clk,
  input logic rst_n,
  sqrt_ctrl_if.master bus
);
  state_t state, nxt;
  ctrl_t cw;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (state == IDLE || state == DONE) nxt = bus.start ? LOAD : state;
    else nxt = state_t'(state + 5'd1);
`ifdef SQRT_CTRL_ABORT_EN
    if (bus.abort) nxt = IDLE;
`endif
  end
  sqrt_ctrl_decode u_dec (.state(state), .cw(cw));
  assign bus.busy = cw.busy;
  assign bus.en_R1 = cw.en_R1;
  assign bus.en_R2 = cw.en_R2;
  assign bus.en_R3 = cw.en_R3;
  assign bus.en_R4 = cw.en_R4;
  assign bus.en_R5 = cw.en_R5;
  assign bus.b1 = cw.b1;
  assign bus.b6 = cw.b6;
  assign bus.b2 = cw.b2;
  assign bus.b3 = cw.b3;
  assign bus.b4 = cw.b4;
  assign bus.b5 = cw.b5;
  assign bus.b7 = cw.b7;
  assign bus.sel_AU1 = cw.sel_AU1;
  assign bus.sel_AU2 = cw.sel_AU2;
  assign bus.Done = cw.Done;
endmodule
